retire_stage: RTL and testbench
===============================

Name: retire_stage

Overview:
- Consumes the three oldest ROB entries each cycle and commits up to three instructions in program order.
- Returns each committed instruction's Told to the free list, updates the architectural map table, and releases committed stores to the SQ.
- Raises a registered precise-state flush on a committed mispredict and a sticky halt on a committed WFI.
- Sits between the ROB head and the free list, arch map table, SQ and fetch redirect; it is the commit-side counterpart of the dispatch stage.

Parameters:
- PR, 6: physical register index width.
- XLEN, 32: PC width.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rob_head_entry  in  3 x ROB_ENTRY_PACKET  head entries; slot 2 = oldest, slot 0 = youngest. Fields used: valid, completed, Tnew, Told, arch_reg, halt, is_store, precise_state_need, target_pc.
- sq_retire_ready  in  1  SQ/dcache can accept one store commit this cycle.
- retire_en  out  3  per-slot commit; the ROB pops popcount(retire_en) entries.
- fl_free_en  out  3  return Told to the free list.
- fl_free_pr  out  3 x PR  Told per slot.
- archmap_en  out  3  arch map table write enable.
- archmap_ar  out  3 x 5  arch register per slot.
- archmap_pr  out  3 x PR  Tnew per slot.
- sq_retire  out  3  commit store in this slot.
- precise_state_valid  out  1  registered flush request to ROB/RS/fetch/map table.
- target_pc  out  XLEN  registered redirect PC, valid with precise_state_valid.
- halt  out  1  registered, sticky.
- retire_count  out  CNT_W  total committed instructions.

Behaviour:
- State machine: RUN, FLUSH, HALTED. Reset enters RUN.
- Reset values: precise_state_valid=0, target_pc=0, halt=0, retire_count=0.
- Combinational outputs (retire_en, fl_free_*, archmap_*, sq_retire) are 0 in FLUSH and HALTED, and while reset is low.

RUN, evaluated oldest-first (slot 2, then 1, then 0):
- A slot commits iff: valid && completed && every older slot commits this cycle && no older slot this cycle is a stop condition.
- Stop conditions end the group after the stopping slot: precise_state_need=1, halt=1.
- Store rule: a slot with is_store=1 commits only if sq_retire_ready=1 and no older slot committed a store this cycle. At most one store commits per cycle; a blocked store also blocks every younger slot.
- Per committed slot k:
  - If arch_reg != 0: fl_free_en[k]=1 with fl_free_pr[k]=Told, and archmap_en[k]=1 with archmap_ar[k]=arch_reg, archmap_pr[k]=Tnew.
  - If is_store: sq_retire[k]=1.
- The data fields of fl_free_pr and archmap_* drive the slot values regardless of enable. They are don't-care when the enable is 0.
- Gaps are illegal: retire_en is always one of 000, 100, 110, 111 (bit 2 = oldest).

Mispredict (precise_state_need):
- The slot commits normally; younger slots do not commit.
- Next edge: state <= FLUSH, precise_state_valid <= 1, target_pc <= that slot's target_pc.
- FLUSH lasts exactly one cycle with no commits, then returns to RUN. precise_state_valid is high for exactly that cycle; target_pc holds its value until the next flush.

Halt:
- The slot commits; younger slots do not commit.
- Next edge: state <= HALTED, halt <= 1.
- HALTED is held until reset; no further commits.
- If one entry has both halt and precise_state_need set, halt wins: go to HALTED, no flush.

Counter:
- retire_count += popcount(retire_en) every edge in RUN; wraps modulo 2^CNT_W.
- The halt or mispredict instruction itself is counted.

Other boundary conditions:
- Head entry invalid or not completed: retire_en=000; state and count unchanged.
- Async reset mid-FLUSH or mid-HALTED: return immediately to RUN with all registered outputs cleared.

Test Plan:
- Three completed ALU entries, arch_reg 1/2/3, Told 10/11/12 -> retire_en=111, fl_free_pr={12,11,10} (slots 0,1,2), archmap_en=111, retire_count 0->3.
- Slot 2 completed, slot 1 not completed, slot 0 completed -> retire_en=100; next cycle, with slot 1 now completed -> 110 (or 111 if slot 0 is also ready).
- Two stores in slots 2 and 1, sq_retire_ready=1 -> cycle 1 sq_retire=100, retire_en=100; cycle 2 (store now at head) -> 100. With sq_retire_ready=0 -> retire_en=000.
- Slot 1 precise_state_need=1, target_pc=0x0000_0040 -> retire_en=110; next cycle precise_state_valid=1, target_pc=0x40, retire_en=000; the cycle after, precise_state_valid=0 and commits resume.
- Slot 2 halt=1, slots 1/0 valid+completed -> retire_en=100, halt=1 next cycle and held, retire_en=000 thereafter; assert reset low -> halt=0, retire_count=0, RUN.
- Entry with arch_reg=0 (branch) plus retire_count preloaded near 2^CNT_W-1 -> fl_free_en=0 and archmap_en=0 for that slot; retire_count wraps to 0 after a single commit.

Source files
------------

// File: rtl/retire_stage.sv
// Commit stage: retires up to three completed ROB head entries per cycle, oldest first.
// Frees Told, updates the arch map and commits stores. Raises a one-cycle flush on a retired mispredict and a sticky halt on a retired WFI.
`timescale 1ns/1ps

module retire_stage #(
   parameter  int PR      = 6,
   parameter  int XLEN    = 32,
   parameter  int CNT_W   = 32,
   // Per-entry layout, MSB first:
   //   valid, completed, halt, is_store, precise_state_need, arch_reg[4:0], Tnew, Told, target_pc
   localparam int ENTRY_W = XLEN + 2*PR + 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [3*ENTRY_W-1:0] rob_head_entry,
   input  logic               sq_retire_ready,
   output logic [2:0]         retire_en,
   output logic [2:0]         fl_free_en,
   output logic [3*PR-1:0]    fl_free_pr,
   output logic [2:0]         archmap_en,
   output logic [14:0]        archmap_ar,
   output logic [3*PR-1:0]    archmap_pr,
   output logic [2:0]         sq_retire,
   output logic               precise_state_valid,
   output logic [XLEN-1:0]    target_pc,
   output logic               halt,
   output logic [CNT_W-1:0]   retire_count
);

   typedef struct packed {
      logic            valid;
      logic            completed;
      logic            halt;
      logic            is_store;
      logic            precise_state_need;
      logic [4:0]      arch_reg;
      logic [PR-1:0]   tnew;
      logic [PR-1:0]   told;
      logic [XLEN-1:0] target_pc;
   } entry_t;

   typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

   entry_t [2:0]    head;
   state_t          state;
   logic            chain_open;
   logic            store_used;
   logic            stop_halt;
   logic            stop_flush;
   logic [XLEN-1:0] stop_pc;

   assign head = rob_head_entry;

   // Walk oldest (slot 2) to youngest; chain_open drops at the first slot that
   // cannot commit or that ends the group, so retire_en never has gaps.
   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      retire_en  = '0;
      fl_free_en = '0;
      fl_free_pr = '0;
      archmap_en = '0;
      archmap_ar = '0;
      archmap_pr = '0;
      sq_retire  = '0;
      stop_halt  = 1'b0;
      stop_flush = 1'b0;
      stop_pc    = '0;
      // NOTE: blocking assignments here are intentional; later slots must see
      // the chain_open/store_used values updated by older slots in this same pass.
      chain_open = reset && (state == RUN);
      store_used = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         if (reset && state == RUN) begin
            fl_free_pr[k*PR +: PR] = head[k].told;
            archmap_ar[k*5 +: 5]   = head[k].arch_reg;
            archmap_pr[k*PR +: PR] = head[k].tnew;
         end
         if (chain_open && head[k].valid && head[k].completed &&
             (!head[k].is_store || (sq_retire_ready && !store_used))) begin
            retire_en[k] = 1'b1;
            if (head[k].arch_reg != 5'd0) begin
               fl_free_en[k] = 1'b1;
               archmap_en[k] = 1'b1;
            end
            if (head[k].is_store) begin
               sq_retire[k] = 1'b1;
               store_used   = 1'b1;
            end
            // Halt takes priority over a mispredict on the same entry.
            if (head[k].halt) begin
               stop_halt  = 1'b1;
               chain_open = 1'b0;
            end else if (head[k].precise_state_need) begin
               stop_flush = 1'b1;
               stop_pc    = head[k].target_pc;
               chain_open = 1'b0;
            end
         end else begin
            chain_open = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state               <= RUN;
         precise_state_valid <= 1'b0;
         target_pc           <= '0;
         halt                <= 1'b0;
         retire_count        <= '0;
      end else begin
         case (state)
            RUN: begin
               retire_count <= retire_count + CNT_W'($countones(retire_en));
               if (stop_halt) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end else if (stop_flush) begin
                  state               <= FLUSH;
                  precise_state_valid <= 1'b1;
                  target_pc           <= stop_pc;
               end
            end
            FLUSH: begin
               precise_state_valid <= 1'b0;
               state               <= RUN;
            end
            HALTED:  state <= HALTED;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: a reference model predicts each cycle's commit
// vector and next registered state into a queue, compared when the DUT responds.
`timescale 1ns/1ps

module tb_retire_stage;

   localparam int PR      = 6;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int ENTRY_W = XLEN + 2*PR + 10;
   localparam int S_RUN   = 0;
   localparam int S_FLUSH = 1;
   localparam int S_HALT  = 2;

   typedef struct packed {
      logic        valid;
      logic        completed;
      logic        halt;
      logic        is_store;
      logic        psn;
      logic [4:0]  ar;
      logic [5:0]  tnew;
      logic [5:0]  told;
      logic [31:0] tpc;
   } ent_t;

   typedef struct {
      logic [2:0]  ren;
      logic [2:0]  fen;
      logic [2:0]  aen;
      logic [2:0]  sq;
      logic [17:0] fpr;
      logic [14:0] aar;
      logic [17:0] apr;
      logic        psv;
      logic [31:0] pc;
      logic        hlt;
      logic [3:0]  cnt;
      int          nst;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [3*ENTRY_W-1:0] rob_head_entry;
   logic                 sq_retire_ready = 1'b1;
   logic [2:0]           retire_en, fl_free_en, archmap_en, sq_retire;
   logic [17:0]          fl_free_pr, archmap_pr;
   logic [14:0]          archmap_ar;
   logic                 precise_state_valid, halt;
   logic [31:0]          target_pc;
   logic [3:0]           retire_count;

   ent_t ent [3];
   exp_t q [$];
   int   m_st = S_RUN;
   logic [31:0] m_pc = '0;
   logic [3:0]  m_cnt = '0;
   logic        m_halt = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   assign rob_head_entry = {ent[2], ent[1], ent[0]};

   always #5 clock = ~clock;

   retire_stage #(.PR(PR), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clock               (clock),
      .reset               (reset),
      .rob_head_entry      (rob_head_entry),
      .sq_retire_ready     (sq_retire_ready),
      .retire_en           (retire_en),
      .fl_free_en          (fl_free_en),
      .fl_free_pr          (fl_free_pr),
      .archmap_en          (archmap_en),
      .archmap_ar          (archmap_ar),
      .archmap_pr          (archmap_pr),
      .sq_retire           (sq_retire),
      .precise_state_valid (precise_state_valid),
      .target_pc           (target_pc),
      .halt                (halt),
      .retire_count        (retire_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t alu(input logic c, input logic [4:0] ar,
                                input logic [5:0] tnew, input logic [5:0] told);
      ent_t e;
      e           = '0;
      e.valid     = 1'b1;
      e.completed = c;
      e.ar        = ar;
      e.tnew      = tnew;
      e.told      = told;
      return e;
   endfunction

   function automatic ent_t st(input logic [5:0] told);
      ent_t e;
      e          = alu(1'b1, 5'd0, 6'd0, told);
      e.is_store = 1'b1;
      return e;
   endfunction

   // Predict this cycle's outputs from the current inputs and model state,
   // queue the prediction, then compare combinational and registered results.
   task automatic step(input string tag);
      exp_t e;
      bit   go;
      bit   used;
      int   n;
      e = '{ren: '0, fen: '0, aen: '0, sq: '0, fpr: '0, aar: '0, apr: '0,
            psv: 1'b0, pc: m_pc, hlt: m_halt, cnt: m_cnt, nst: m_st};
      if (!reset) begin
         e.pc  = '0;
         e.hlt = 1'b0;
         e.cnt = '0;
         e.nst = S_RUN;
      end else if (m_st == S_FLUSH) begin
         e.nst = S_RUN;
      end else if (m_st == S_RUN) begin
         go   = 1'b1;
         used = 1'b0;
         n    = 0;
         for (int s = 2; s >= 0 && go; s--) begin
            if (!ent[s].valid || !ent[s].completed) go = 1'b0;
            else if (ent[s].is_store && (!sq_retire_ready || used)) go = 1'b0;
            else begin
               n++;
               e.ren[s]          = 1'b1;
               e.fpr[s*6 +: 6]   = ent[s].told;
               e.apr[s*6 +: 6]   = ent[s].tnew;
               e.aar[s*5 +: 5]   = ent[s].ar;
               e.fen[s]          = (ent[s].ar != 5'd0);
               e.aen[s]          = (ent[s].ar != 5'd0);
               if (ent[s].is_store) begin
                  e.sq[s] = 1'b1;
                  used    = 1'b1;
               end
               if (ent[s].halt) begin
                  e.hlt = 1'b1;
                  e.nst = S_HALT;
                  go    = 1'b0;
               end else if (ent[s].psn) begin
                  e.psv = 1'b1;
                  e.pc  = ent[s].tpc;
                  e.nst = S_FLUSH;
                  go    = 1'b0;
               end
            end
         end
         e.cnt = m_cnt + 4'(n);
      end
      q.push_back(e);

      #2;
      e = q.pop_front();
      check({tag, "/retire_en"},  32'(retire_en),  32'(e.ren));
      check({tag, "/fl_free_en"}, 32'(fl_free_en), 32'(e.fen));
      check({tag, "/archmap_en"}, 32'(archmap_en), 32'(e.aen));
      check({tag, "/sq_retire"},  32'(sq_retire),  32'(e.sq));
      for (int k = 0; k < 3; k++) begin
         if (e.fen[k]) begin
            check({tag, "/fl_free_pr"}, 32'(fl_free_pr[k*6 +: 6]), 32'(e.fpr[k*6 +: 6]));
            check({tag, "/archmap_ar"}, 32'(archmap_ar[k*5 +: 5]), 32'(e.aar[k*5 +: 5]));
            check({tag, "/archmap_pr"}, 32'(archmap_pr[k*6 +: 6]), 32'(e.apr[k*6 +: 6]));
         end
      end

      @(posedge clock);
      #1;
      check({tag, "/precise_state_valid"}, 32'(precise_state_valid), 32'(e.psv));
      check({tag, "/target_pc"},           target_pc,                e.pc);
      check({tag, "/halt"},                32'(halt),                32'(e.hlt));
      check({tag, "/retire_count"},        32'(retire_count),        32'(e.cnt));
      m_st   = e.nst;
      m_pc   = e.pc;
      m_cnt  = e.cnt;
      m_halt = e.hlt;
   endtask

   // Reset asserted between clock edges must clear registered state at once.
   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      check({tag, "/precise_state_valid"}, 32'(precise_state_valid), 32'd0);
      check({tag, "/target_pc"},           target_pc,                32'd0);
      check({tag, "/halt"},                32'(halt),                32'd0);
      check({tag, "/retire_count"},        32'(retire_count),        32'd0);
      check({tag, "/retire_en"},           32'(retire_en),           32'd0);
      m_st   = S_RUN;
      m_pc   = '0;
      m_cnt  = '0;
      m_halt = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   initial begin
      ent[2] = alu(1'b1, 5'd1, 6'd20, 6'd10);
      ent[1] = alu(1'b1, 5'd2, 6'd21, 6'd11);
      ent[0] = alu(1'b1, 5'd3, 6'd22, 6'd12);
      step("in_reset");
      reset = 1'b1;
      step("alu3");

      ent[2] = alu(1'b1, 5'd4, 6'd23, 6'd13);
      ent[1] = alu(1'b0, 5'd5, 6'd24, 6'd14);
      ent[0] = alu(1'b1, 5'd6, 6'd25, 6'd15);
      step("gap_blocked");
      ent[2] = alu(1'b1, 5'd5, 6'd24, 6'd14);
      ent[1] = alu(1'b1, 5'd6, 6'd25, 6'd15);
      ent[0] = alu(1'b1, 5'd7, 6'd26, 6'd16);
      step("gap_filled");

      ent[2] = st(6'd30);
      ent[1] = st(6'd31);
      ent[0] = alu(1'b1, 5'd8, 6'd27, 6'd17);
      step("two_stores");
      ent[2] = st(6'd31);
      ent[1] = alu(1'b1, 5'd8, 6'd27, 6'd17);
      ent[0] = alu(1'b1, 5'd9, 6'd28, 6'd18);
      step("store_head");
      sq_retire_ready = 1'b0;
      ent[2] = st(6'd32);
      step("sq_busy_head");
      ent[2] = alu(1'b1, 5'd10, 6'd29, 6'd19);
      ent[1] = st(6'd32);
      step("sq_busy_slot1");
      sq_retire_ready = 1'b1;

      ent[2] = alu(1'b0, 5'd11, 6'd33, 6'd34);
      step("head_incomplete");
      ent[2].valid = 1'b0;
      step("head_invalid");

      ent[2] = alu(1'b1, 5'd12, 6'd35, 6'd36);
      ent[1] = alu(1'b1, 5'd0, 6'd0, 6'd0);
      ent[1].psn = 1'b1;
      ent[1].tpc = 32'h0000_0040;
      ent[0] = alu(1'b1, 5'd13, 6'd37, 6'd38);
      step("mispredict");
      ent[2] = alu(1'b1, 5'd13, 6'd37, 6'd38);
      ent[1] = alu(1'b1, 5'd14, 6'd39, 6'd40);
      ent[0] = alu(1'b1, 5'd15, 6'd41, 6'd42);
      step("flush_cycle");
      step("resume");

      ent[2].psn = 1'b1;
      ent[2].tpc = 32'h0000_0080;
      step("mispredict_head");
      async_reset("reset_in_flush");
      ent[2].psn = 1'b0;
      step("after_flush_reset");

      ent[2].halt = 1'b1;
      ent[2].psn  = 1'b1;
      ent[2].tpc  = 32'h0000_00c0;
      step("halt_and_psn");
      ent[2].halt = 1'b0;
      ent[2].psn  = 1'b0;
      step("halted_1");
      step("halted_2");
      async_reset("reset_in_halt");

      for (int i = 0; i < 5; i++) step("fill_count");
      ent[2] = alu(1'b1, 5'd0, 6'd43, 6'd44);
      ent[1].valid = 1'b0;
      step("branch_wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
